pix_wr_combiner: RTL and testbench
==================================

PIX_WR_COMBINER -- requirements
Module: pix_wr_combiner

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data width of both ports; only 32 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: byte address width of both ports.
REQ-003 SHALL have parameter FLUSH_TIMEOUT, default 16: idle cycles before a held write is flushed.
REQ-004 SHALL have parameter MAX_WR_OUTSTANDING, default 3: maximum downstream writes awaiting a response.
REQ-005 SHALL have port aclk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port areset, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have upstream ports from the cel engine, as a mem_if slave: up_req in 1, up_addr in ADDR_WIDTH, up_we in 1, up_wdata in DATA_WIDTH, up_be in 4, up_gnt out 1, up_rsp_valid out 1, up_rsp_rdata out DATA_WIDTH, up_rsp_error out 1.
REQ-008 SHALL have downstream ports to memory, as a mem_if master: dn_req out 1, dn_addr out ADDR_WIDTH, dn_we out 1, dn_wdata out DATA_WIDTH, dn_be out 4, dn_gnt in 1, dn_rsp_valid in 1, dn_rsp_rdata in DATA_WIDTH, dn_rsp_error in 1.
REQ-009 SHALL have port flush_i, input, 1: forces the held write downstream.
REQ-010 SHALL have port idle_o, output, 1: high when the buffer is empty, nothing is outstanding and no upstream request is pending.
REQ-011 SHALL have port wr_err_o, output, 1: sticky flag for a downstream write error.

Function
REQ-012 SHALL implement states IDLE (buffer empty), HOLD (one word buffered), FLUSH (buffered write on dn, waiting for dn_gnt), RD_REQ (read on dn, waiting for dn_gnt) and RD_WAIT (waiting for the read response).
REQ-013 SHALL, on an upstream write in IDLE, assert up_gnt in the same cycle, latch {addr[31:2], wdata, be} and go to HOLD.
REQ-014 SHALL, on an upstream write in HOLD to the same word (addr[31:2] equal), assert up_gnt in the same cycle, overwrite only the bytes set in up_be, and OR up_be into the held be.
REQ-015 SHALL, on an upstream write in HOLD to a different word, hold up_gnt low and go to FLUSH; the new write is accepted in IDLE after dn_gnt.
REQ-016 SHALL go to FLUSH on the cycle after the held be becomes 4'hF.
REQ-017 SHALL go from HOLD to FLUSH when flush_i is high.
REQ-018 SHALL, in FLUSH, drive dn_req=1, dn_we=1, dn_addr={word,2'b00}, the held data and the held be, stable until dn_gnt; then go to IDLE and increment the write-outstanding count.
REQ-019 SHALL hold dn_req low in FLUSH while the write-outstanding count equals MAX_WR_OUTSTANDING.
REQ-020 SHALL assert up_rsp_valid with up_rsp_error=0 exactly one cycle after each upstream write grant.
REQ-021 SHALL, for an upstream read, first flush any held word, then wait until the write-outstanding count is 0, then go to RD_REQ and forward the read unchanged.
REQ-022 SHALL assert up_gnt for a read in the same cycle as dn_gnt.
REQ-023 SHALL, in RD_WAIT, pass dn_rsp_valid, dn_rsp_rdata and dn_rsp_error to upstream with no register stage, then go to IDLE.
REQ-024 SHALL not grant any upstream request while in RD_REQ or RD_WAIT (one read outstanding).
REQ-025 SHALL, on a dn_rsp_valid while the write-outstanding count is above 0, decrement the count, not forward the response upstream, and set wr_err_o if dn_rsp_error is high.
REQ-026 SHALL give priority to a simultaneous flush_i, timeout and merging write: the merge completes first and the flush follows on the next cycle.

Reset
REQ-027 SHALL, while areset is high, drive state=IDLE, all dn_* outputs 0, up_gnt=0, up_rsp_valid=0, up_rsp_rdata=0, up_rsp_error=0, wr_err_o=0, idle_o=1, counters 0.
REQ-028 SHALL discard a held word or an in-flight read if reset is asserted mid-operation; no response is issued after reset.

Configuration
REQ-029 SHALL, when PIX_WR_COMB_TIMEOUT_EN is defined, count consecutive cycles in HOLD with no upstream request and go to FLUSH when the count reaches FLUSH_TIMEOUT; the count clears on any accepted write.
REQ-030 SHALL, when PIX_WR_COMB_TIMEOUT_EN is undefined, leave HOLD only via REQ-015, REQ-016, REQ-017 or REQ-021, with no timeout counter present.

Structure
REQ-031 SHALL place the pwc_state_t enum and the constant PWC_BE_FULL=4'hF in mcore_pkg.
REQ-032 SHALL place the timeout counter in the sub-module pwc_timeout_ctr, instantiated only under PIX_WR_COMB_TIMEOUT_EN.

Verification
REQ-033 SHALL cover: write 0x100 be=0011 data 0x0000_1234, then write 0x102 be=1100 data 0x5678_0000 -> one dn write to 0x100, be=1111, data 0x5678_1234.
REQ-034 SHALL cover: write 0x100 be=0011, then write 0x200 -> dn write to 0x100 with be=0011 first; the 0x200 write is granted only after that dn_gnt.
REQ-035 SHALL cover: write 0x100 be=0001, then read 0x100 -> dn write issued, its response absorbed, then dn read issued; upstream receives only the read data.
REQ-036 SHALL cover: with the macro defined and FLUSH_TIMEOUT=16, a single write followed by idle -> dn_req rises exactly 16 cycles after HOLD is entered; with the macro undefined, no dn_req until flush_i.
REQ-037 SHALL cover: dn_gnt held low with 4 pending flushes -> a 4th dn write is not issued; dn_rsp_error=1 on a write response -> wr_err_o=1 until reset.
REQ-038 SHALL cover: areset pulsed while in HOLD -> no dn write, idle_o=1 on the first cycle after reset.

Source files
------------

// File: rtl/mcore_pkg.sv
// Shared types and constants for the pixel write combiner.
// pwc_state_t : controller states
// PWC_BE_FULL : byte-enable value of a completely written word
package mcore_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLD    = 3'd1,
        FLUSH   = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4
    } pwc_state_t;

    localparam logic [3:0] PWC_BE_FULL = 4'hF;

    // Overwrite only the bytes of the held word that the new write enables.
    function automatic logic [31:0] pwc_merge(input logic [31:0] held,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
        logic [31:0] res;
        res = held;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/pwc_timeout_ctr.sv
// Idle timeout for a held write. Down-counter reloaded whenever the combiner
// is not sitting idle in HOLD; expire_o fires on the last idle cycle so the
// FSM enters FLUSH exactly FLUSH_TIMEOUT cycles after HOLD was entered.
// Only built when PIX_WR_COMB_TIMEOUT_EN is defined.
module pwc_timeout_ctr #(
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic hold_idle_i,
    output logic expire_o
);

    localparam int              CNT_W = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LOAD  = CNT_W'(FLUSH_TIMEOUT);
    localparam logic [CNT_W-1:0] TC    = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count down while idle in HOLD, reload otherwise.
    always_comb begin
        cnt_d = LOAD;
        if (hold_idle_i) cnt_d = cnt_q - TC;
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= LOAD;
        else       cnt_q <= cnt_d;
    end

    assign expire_o = hold_idle_i && (cnt_q == TC);

endmodule

// File: rtl/pix_wr_combiner.sv
// Pixel write combiner: merges partial upstream writes to the same 32-bit
// word into one downstream write, tracks outstanding downstream writes and
// serialises reads behind them.
// Optional idle flush timeout: define PIX_WR_COMB_TIMEOUT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------
// IDLE    | buffer empty
// HOLD    | one word buffered, merging same-word writes
// FLUSH   | buffered write on dn, waiting for dn_gnt
// RD_REQ  | read forwarded on dn, waiting for dn_gnt
// RD_WAIT | waiting for the read response, passed straight through
module pix_wr_combiner
    import mcore_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 32,
    parameter int FLUSH_TIMEOUT      = 16,
    parameter int MAX_WR_OUTSTANDING = 3
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  up_req,
    input  logic [ADDR_WIDTH-1:0] up_addr,
    input  logic                  up_we,
    input  logic [DATA_WIDTH-1:0] up_wdata,
    input  logic [3:0]            up_be,
    output logic                  up_gnt,
    output logic                  up_rsp_valid,
    output logic [DATA_WIDTH-1:0] up_rsp_rdata,
    output logic                  up_rsp_error,
    output logic                  dn_req,
    output logic [ADDR_WIDTH-1:0] dn_addr,
    output logic                  dn_we,
    output logic [DATA_WIDTH-1:0] dn_wdata,
    output logic [3:0]            dn_be,
    input  logic                  dn_gnt,
    input  logic                  dn_rsp_valid,
    input  logic [DATA_WIDTH-1:0] dn_rsp_rdata,
    input  logic                  dn_rsp_error,
    input  logic                  flush_i,
    output logic                  idle_o,
    output logic                  wr_err_o
);

    localparam int               CNT_W  = $clog2(MAX_WR_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] WR_MAX = CNT_W'(MAX_WR_OUTSTANDING);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    pwc_state_t            state_q, state_d;
    logic [ADDR_WIDTH-3:0] word_q, word_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [3:0]            be_q, be_d;
    logic [CNT_W-1:0]      wr_out_q, wr_out_d;
    logic                  rsp_pend_q, rsp_pend_d;
    logic                  wr_err_q, wr_err_d;

    logic gnt;
    logic tmo;
    logic same_word;
    logic wr_issue;
    logic wr_rsp;

    assign same_word = (up_addr[ADDR_WIDTH-1:2] == word_q);

`ifdef PIX_WR_COMB_TIMEOUT_EN
    logic hold_idle;
    assign hold_idle = (state_q == HOLD) && !up_req;

    pwc_timeout_ctr #(
        .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
    ) u_timeout_ctr (
        .clk_i      (aclk),
        .rst_i      (areset),
        .hold_idle_i(hold_idle),
        .expire_o   (tmo)
    );
`else
    logic unused_flush_timeout;
    assign unused_flush_timeout = (FLUSH_TIMEOUT != 0);
    assign tmo = 1'b0;
`endif

    // Next-state, buffer update and downstream drive.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        data_d   = data_q;
        be_d     = be_q;
        gnt      = 1'b0;
        dn_req   = 1'b0;
        dn_we    = 1'b0;
        dn_addr  = '0;
        dn_wdata = '0;
        dn_be    = '0;
        case (state_q)
            IDLE: begin
                if (up_req) begin
                    if (up_we) begin
                        gnt     = 1'b1;
                        word_d  = up_addr[ADDR_WIDTH-1:2];
                        data_d  = up_wdata;
                        be_d    = up_be;
                        state_d = HOLD;
                    end else if (wr_out_q == '0) begin
                        state_d = RD_REQ;
                    end
                end
            end
            HOLD: begin
                if (be_q == PWC_BE_FULL) begin
                    state_d = FLUSH;
                end else if (up_req && up_we && same_word) begin
                    // merge wins; a coincident flush or timeout follows next cycle
                    gnt    = 1'b1;
                    data_d = pwc_merge(data_q, up_wdata, up_be);
                    be_d   = be_q | up_be;
                    if (flush_i || tmo) state_d = FLUSH;
                end else if (flush_i || tmo || up_req) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                dn_req   = (wr_out_q != WR_MAX);
                dn_we    = 1'b1;
                dn_addr  = {word_q, 2'b00};
                dn_wdata = data_q;
                dn_be    = be_q;
                if (dn_req && dn_gnt) state_d = IDLE;
            end
            RD_REQ: begin
                dn_req   = up_req && !up_we;
                dn_addr  = up_addr;
                dn_wdata = up_wdata;
                dn_be    = up_be;
                if (dn_req && dn_gnt) begin
                    gnt     = 1'b1;
                    state_d = RD_WAIT;
                end else if (!dn_req) begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                if (dn_rsp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outstanding-write bookkeeping and write-response generation.
    always_comb begin
        wr_issue   = (state_q == FLUSH) && dn_req && dn_gnt;
        wr_rsp     = dn_rsp_valid && (wr_out_q != '0) && (state_q != RD_WAIT);
        wr_out_d   = wr_out_q;
        if (wr_issue && !wr_rsp)      wr_out_d = wr_out_q + ONE;
        else if (!wr_issue && wr_rsp) wr_out_d = wr_out_q - ONE;
        wr_err_d   = wr_err_q | (wr_rsp & dn_rsp_error);
        rsp_pend_d = gnt && up_we;
    end

    // State and datapath registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= IDLE;
            word_q     <= '0;
            data_q     <= '0;
            be_q       <= '0;
            wr_out_q   <= '0;
            rsp_pend_q <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            data_q     <= data_d;
            be_q       <= be_d;
            wr_out_q   <= wr_out_d;
            rsp_pend_q <= rsp_pend_d;
            wr_err_q   <= wr_err_d;
        end
    end

    // up_gnt is combinational from up_req, so it is masked during reset.
    assign up_gnt       = gnt && !areset;
    assign up_rsp_valid = rsp_pend_q || ((state_q == RD_WAIT) && dn_rsp_valid);
    assign up_rsp_rdata = (state_q == RD_WAIT) ? dn_rsp_rdata : '0;
    assign up_rsp_error = (state_q == RD_WAIT) && dn_rsp_valid && dn_rsp_error;
    assign idle_o       = areset || ((state_q == IDLE) && (wr_out_q == '0) && !up_req);
    assign wr_err_o     = wr_err_q;

endmodule

// File: tb/tb_pix_wr_combiner.sv
// Directed bench for pix_wr_combiner; the downstream memory is played by hand.
module tb_pix_wr_combiner;

    logic        aclk = 1'b0;
    logic        areset;
    logic        up_req, up_we;
    logic [31:0] up_addr, up_wdata;
    logic [3:0]  up_be;
    logic        up_gnt, up_rsp_valid, up_rsp_error;
    logic [31:0] up_rsp_rdata;
    logic        dn_req, dn_we;
    logic [31:0] dn_addr, dn_wdata;
    logic [3:0]  dn_be;
    logic        dn_gnt, dn_rsp_valid, dn_rsp_error;
    logic [31:0] dn_rsp_rdata;
    logic        flush_i, idle_o, wr_err_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    pix_wr_combiner dut (
        .aclk(aclk), .areset(areset),
        .up_req(up_req), .up_addr(up_addr), .up_we(up_we), .up_wdata(up_wdata),
        .up_be(up_be), .up_gnt(up_gnt), .up_rsp_valid(up_rsp_valid),
        .up_rsp_rdata(up_rsp_rdata), .up_rsp_error(up_rsp_error),
        .dn_req(dn_req), .dn_addr(dn_addr), .dn_we(dn_we), .dn_wdata(dn_wdata),
        .dn_be(dn_be), .dn_gnt(dn_gnt), .dn_rsp_valid(dn_rsp_valid),
        .dn_rsp_rdata(dn_rsp_rdata), .dn_rsp_error(dn_rsp_error),
        .flush_i(flush_i), .idle_o(idle_o), .wr_err_o(wr_err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_up(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] b);
        @(negedge aclk);
        up_req = 1'b1; up_we = 1'b1; up_addr = a; up_wdata = d; up_be = b;
        #1 check({tag, "_gnt"}, up_gnt, 1);
        @(negedge aclk);
        up_req = 1'b0; up_we = 1'b0;
        #1 check({tag, "_rsp"}, up_rsp_valid, 1);
        check({tag, "_rsp_err"}, up_rsp_error, 0);
    endtask

    task automatic wait_dn(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            #1;
            if (dn_req) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_req_seen"}, ok, 1);
    endtask

    task automatic dn_accept(input string tag, input logic [31:0] a, input logic we,
                             input logic [31:0] d, input logic [3:0] b);
        bit ok;
        wait_dn(tag, ok);
        if (ok) begin
            check({tag, "_addr"}, dn_addr, a);
            check({tag, "_we"}, dn_we, we);
            check({tag, "_data"}, dn_wdata, d);
            check({tag, "_be"}, dn_be, b);
            dn_gnt = 1'b1;
            @(negedge aclk);
            dn_gnt = 1'b0;
        end
    endtask

    // Downstream write response: must be absorbed, never seen upstream.
    task automatic dn_resp(input string tag, input logic err);
        @(negedge aclk);
        dn_rsp_valid = 1'b1; dn_rsp_error = err; dn_rsp_rdata = 32'hDEADBEEF;
        #1 check({tag, "_absorbed"}, up_rsp_valid, 0);
        @(negedge aclk);
        dn_rsp_valid = 1'b0; dn_rsp_error = 1'b0;
    endtask

    task automatic push(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b);
        write_up(tag, a, d, b);
        @(negedge aclk);
        flush_i = 1'b1;
        @(negedge aclk);
        flush_i = 1'b0;
    endtask

    initial begin
        int cyc;
        int highs;
        bit ok;
        areset = 1'b1; flush_i = 1'b0;
        up_req = 1'b1; up_we = 1'b1; up_addr = 32'h100; up_wdata = 32'h1; up_be = 4'h1;
        dn_gnt = 1'b0; dn_rsp_valid = 1'b0; dn_rsp_error = 1'b0; dn_rsp_rdata = 32'h0;

        // reset values, with an upstream request already pending
        repeat (2) @(negedge aclk);
        #1;
        check("rst_up_gnt", up_gnt, 0);
        check("rst_idle", idle_o, 1);
        check("rst_dn_req", dn_req, 0);
        check("rst_dn_addr", dn_addr, 0);
        check("rst_dn_wdata", dn_wdata, 0);
        check("rst_dn_be", dn_be, 0);
        check("rst_dn_we", dn_we, 0);
        check("rst_rsp_valid", up_rsp_valid, 0);
        check("rst_rsp_rdata", up_rsp_rdata, 0);
        check("rst_rsp_err", up_rsp_error, 0);
        check("rst_wr_err", wr_err_o, 0);
        @(negedge aclk);
        up_req = 1'b0; up_we = 1'b0; areset = 1'b0;
        @(negedge aclk);
        #1 check("post_rst_idle", idle_o, 1);

        // two half-word writes merge into one full downstream write
        write_up("t1_w0", 32'h100, 32'h0000_1234, 4'b0011);
        write_up("t1_w1", 32'h102, 32'h5678_0000, 4'b1100);
        dn_accept("t1_dn", 32'h100, 1'b1, 32'h5678_1234, 4'hF);
        @(negedge aclk);
        #1 check("t1_single_dn", dn_req, 0);
        check("t1_busy", idle_o, 0);
        dn_resp("t1_rsp", 1'b0);
        @(negedge aclk);
        #1 check("t1_idle", idle_o, 1);

        // different word: held word goes first, new write granted after dn_gnt
        write_up("t2_w0", 32'h100, 32'hAAAA_BBBB, 4'b0011);
        @(negedge aclk);
        up_req = 1'b1; up_we = 1'b1; up_addr = 32'h200; up_wdata = 32'h1122_3344; up_be = 4'b0110;
        #1 check("t2_stall", up_gnt, 0);
        @(negedge aclk);
        #1 check("t2_dn_req", dn_req, 1);
        check("t2_dn_addr", dn_addr, 32'h100);
        check("t2_dn_be", dn_be, 4'b0011);
        check("t2_dn_data", dn_wdata, 32'hAAAA_BBBB);
        check("t2_stall_flush", up_gnt, 0);
        dn_gnt = 1'b1;
        #1 check("t2_stall_dn_gnt", up_gnt, 0);
        @(negedge aclk);
        dn_gnt = 1'b0;
        #1 check("t2_gnt_after", up_gnt, 1);
        @(negedge aclk);
        up_req = 1'b0; up_we = 1'b0;
        #1 check("t2_w1_rsp", up_rsp_valid, 1);
        dn_resp("t2_rsp0", 1'b0);
        @(negedge aclk);
        flush_i = 1'b1;
        @(negedge aclk);
        flush_i = 1'b0;
        dn_accept("t2_dn1", 32'h200, 1'b1, 32'h1122_3344, 4'b0110);
        dn_resp("t2_rsp1", 1'b0);

        // read behind a held write: flush, absorb its response, then forward the read
        write_up("t3_w", 32'h100, 32'h0000_00EE, 4'b0001);
        @(negedge aclk);
        up_req = 1'b1; up_we = 1'b0; up_addr = 32'h100; up_wdata = 32'h0; up_be = 4'hF;
        #1 check("t3_rd_stall", up_gnt, 0);
        dn_accept("t3_dn_wr", 32'h100, 1'b1, 32'h0000_00EE, 4'b0001);
        @(negedge aclk);
        #1 check("t3_rd_waits_wr", dn_req, 0);
        check("t3_rd_no_gnt", up_gnt, 0);
        dn_resp("t3_wr_rsp", 1'b0);
        wait_dn("t3_rd", ok);
        check("t3_rd_we", dn_we, 0);
        check("t3_rd_addr", dn_addr, 32'h100);
        check("t3_rd_gnt_early", up_gnt, 0);
        dn_gnt = 1'b1;
        #1 check("t3_rd_gnt", up_gnt, 1);
        @(negedge aclk);
        dn_gnt = 1'b0;
        up_req = 1'b1; up_we = 1'b1; up_addr = 32'h300; up_wdata = 32'h0BAD_BEEF; up_be = 4'hF;
        #1 check("t3_no_gnt_rd_wait", up_gnt, 0);
        check("t3_no_rsp_yet", up_rsp_valid, 0);
        @(negedge aclk);
        dn_rsp_valid = 1'b1; dn_rsp_rdata = 32'hCAFE_F00D; dn_rsp_error = 1'b0;
        #1 check("t3_rd_rsp_valid", up_rsp_valid, 1);
        check("t3_rd_rsp_data", up_rsp_rdata, 32'hCAFE_F00D);
        check("t3_rd_rsp_err", up_rsp_error, 0);
        check("t3_no_gnt_rsp", up_gnt, 0);
        @(negedge aclk);
        dn_rsp_valid = 1'b0;
        #1 check("t3_wr_after_rd", up_gnt, 1);
        @(negedge aclk);
        up_req = 1'b0; up_we = 1'b0;
        #1 check("t3_wr_rsp_up", up_rsp_valid, 1);
        check("t3_wr_rsp_data", up_rsp_rdata, 0);
        dn_accept("t3_dn_full", 32'h300, 1'b1, 32'h0BAD_BEEF, 4'hF);
        dn_resp("t3_rsp_full", 1'b0);

        // single write then idle
        write_up("t4_w", 32'h400, 32'h0000_00AA, 4'b0001);
`ifdef PIX_WR_COMB_TIMEOUT_EN
        cyc = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            #1;
            cyc++;
            if (dn_req) break;
        end
        check("t4_tmo_cycle", cyc, 17);
        check("t4_tmo_addr", dn_addr, 32'h400);
        dn_gnt = 1'b1;
        @(negedge aclk);
        dn_gnt = 1'b0;
`else
        highs = 0;
        repeat (30) begin
            @(negedge aclk);
            #1;
            if (dn_req) highs++;
        end
        check("t4_no_tmo", highs, 0);
        @(negedge aclk);
        flush_i = 1'b1;
        @(negedge aclk);
        flush_i = 1'b0;
        dn_accept("t4_dn", 32'h400, 1'b1, 32'h0000_00AA, 4'b0001);
`endif
        dn_resp("t4_rsp", 1'b0);

        // merge with coincident flush_i: merge lands first, flush next cycle
        write_up("t5_w0", 32'h500, 32'h0000_0011, 4'b0001);
        @(negedge aclk);
        up_req = 1'b1; up_we = 1'b1; up_addr = 32'h501; up_wdata = 32'h0000_2200; up_be = 4'b0010;
        flush_i = 1'b1;
        #1 check("t5_merge_gnt", up_gnt, 1);
        @(negedge aclk);
        up_req = 1'b0; up_we = 1'b0; flush_i = 1'b0;
        #1 check("t5_merge_rsp", up_rsp_valid, 1);
        check("t5_flush_next", dn_req, 1);
        check("t5_dn_data", dn_wdata, 32'h0000_2211);
        check("t5_dn_be", dn_be, 4'b0011);
        dn_gnt = 1'b1;
        @(negedge aclk);
        dn_gnt = 1'b0;
        // fill up to the outstanding limit without responses
        push("t5_p1", 32'h600, 32'h0000_0066, 4'b0001);
        dn_accept("t5_dn1", 32'h600, 1'b1, 32'h0000_0066, 4'b0001);
        push("t5_p2", 32'h700, 32'h0000_0077, 4'b0001);
        dn_accept("t5_dn2", 32'h700, 1'b1, 32'h0000_0077, 4'b0001);
        push("t5_p3", 32'h800, 32'h0000_0088, 4'b0001);
        highs = 0;
        repeat (6) begin
            @(negedge aclk);
            #1;
            if (dn_req) highs++;
        end
        check("t5_max_outstanding", highs, 0);
        check("t5_err_clear", wr_err_o, 0);
        dn_resp("t5_err_rsp", 1'b1);
        #1 check("t5_wr_err", wr_err_o, 1);
        dn_accept("t5_dn3", 32'h800, 1'b1, 32'h0000_0088, 4'b0001);
        dn_resp("t5_r1", 1'b0);
        dn_resp("t5_r2", 1'b0);
        dn_resp("t5_r3", 1'b0);
        @(negedge aclk);
        #1 check("t5_err_sticky", wr_err_o, 1);
        check("t5_idle", idle_o, 1);

        // reset while holding a word
        write_up("t6_w", 32'h900, 32'h0000_0099, 4'b0001);
        @(negedge aclk);
        areset = 1'b1;
        #1 check("t6_rst_idle", idle_o, 1);
        check("t6_rst_dn_req", dn_req, 0);
        check("t6_rst_wr_err", wr_err_o, 0);
        @(negedge aclk);
        areset = 1'b0;
        #1 check("t6_idle_after", idle_o, 1);
        check("t6_dn_req_after", dn_req, 0);
        highs = 0;
        cyc = 0;
        repeat (25) begin
            @(negedge aclk);
            #1;
            if (dn_req) highs++;
            if (up_rsp_valid) cyc++;
        end
        check("t6_no_dn_write", highs, 0);
        check("t6_no_rsp", cyc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
